// File: rtl/rot_shift_pipe.sv
// Pipelined rotate/shift unit (ROL, ROR, SLL, SRL, SRA, pass-through) over a log2(WIDTH)-level
// barrel network, REG_EVERY levels per register stage. Optional out_zero flag: ROT_SHIFT_ZERO_FLAG_EN.
module rot_shift_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
`ifdef ROT_SHIFT_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);

  localparam int LOG = $clog2(WIDTH);
  localparam int S   = (LOG + REG_EVERY - 1) / REG_EVERY;

  // Handshake: a beat is accepted on in_valid && in_ready, a result consumed on
  // out_valid && out_ready. The whole pipe advances together when the output slot
  // is empty or being consumed; otherwise every stage holds.
  logic advance;

  logic [S-1:0]       valid_q, valid_d;
  logic [S-1:0]       sgn_q, sgn_d;
  logic [WIDTH-1:0]   data_q [S];
  logic [WIDTH-1:0]   data_d [S];
  logic [LOG-1:0]     amt_q  [S];
  logic [LOG-1:0]     amt_d  [S];
  logic [2:0]         op_q   [S];
  logic [2:0]         op_d   [S];
  logic [TAG_W-1:0]   tag_q  [S];
  logic [TAG_W-1:0]   tag_d  [S];

  // Stage inputs: index 0 is the accepted beat, index s is stage s-1's register.
  logic [S-1:0]       src_valid;
  logic [S-1:0]       src_sgn;
  logic [WIDTH-1:0]   src_data [S];
  logic [LOG-1:0]     src_amt  [S];
  logic [2:0]         src_op   [S];
  logic [TAG_W-1:0]   src_tag  [S];

  // One barrel level: shift/rotate by the constant n. SRA fills with the sign
  // bit captured at accept, since intermediate data no longer carries it.
  function automatic logic [WIDTH-1:0] lvl_shift(input logic [WIDTH-1:0] d,
                                                 input logic [2:0]       op,
                                                 input logic             sgn,
                                                 input int               n);
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> n) : '0;
    case (op)
      3'b000:  lvl_shift = (d << n) | (d >> (WIDTH - n));
      3'b001:  lvl_shift = (d >> n) | (d << (WIDTH - n));
      3'b010:  lvl_shift = d << n;
      3'b011:  lvl_shift = d >> n;
      3'b100:  lvl_shift = (d >> n) | fill;
      default: lvl_shift = d;
    endcase
  endfunction

  assign advance   = !valid_q[S-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_tag   = tag_q[S-1];

  always_comb begin
    src_valid[0] = in_valid && advance;
    src_sgn[0]   = in_data[WIDTH-1];
    src_data[0]  = in_data;
    src_amt[0]   = in_shamt;
    src_op[0]    = in_op;
    src_tag[0]   = in_tag;
    for (int s = 1; s < S; s++) begin
      src_valid[s] = valid_q[s-1];
      src_sgn[s]   = sgn_q[s-1];
      src_data[s]  = data_q[s-1];
      src_amt[s]   = amt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_tag[s]   = tag_q[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < S; s++) begin
      valid_d[s] = src_valid[s];
      sgn_d[s]   = src_sgn[s];
      amt_d[s]   = src_amt[s];
      op_d[s]    = src_op[s];
      tag_d[s]   = src_tag[s];
      data_d[s]  = src_data[s];
      // Stage s owns barrel levels s*REG_EVERY .. s*REG_EVERY+REG_EVERY-1.
      for (int l = 0; l < LOG; l++) begin
        if ((l / REG_EVERY) == s && src_amt[s][l]) begin
          data_d[s] = lvl_shift(data_d[s], src_op[s], src_sgn[s], 1 << l);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      sgn_q   <= '0;
      for (int s = 0; s < S; s++) begin
        data_q[s] <= '0;
        amt_q[s]  <= '0;
        op_q[s]   <= '0;
        tag_q[s]  <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      sgn_q   <= sgn_d;
      for (int s = 0; s < S; s++) begin
        data_q[s] <= data_d[s];
        amt_q[s]  <= amt_d[s];
        op_q[s]   <= op_d[s];
        tag_q[s]  <= tag_d[s];
      end
    end
  end

`ifdef ROT_SHIFT_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (advance) begin
      zero_q <= valid_d[S-1] && (data_d[S-1] == '0);
    end
  end

  assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_rot_shift_pipe.sv
// Self-checking bench for rot_shift_pipe (WIDTH=32, REG_EVERY=2, latency 3); random and directed
// beats scored against a reference model. Zero-flag scenario active with ROT_SHIFT_ZERO_FLAG_EN.
module tb_rot_shift_pipe;

  localparam int W   = 32;
  localparam int TW  = 5;
  localparam int LAT = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [4:0]    in_shamt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef ROT_SHIFT_ZERO_FLAG_EN
  logic          out_zero;
`endif

  rot_shift_pipe #(.WIDTH(W), .REG_EVERY(2), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef ROT_SHIFT_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] exp_tag_q[$];
  int            exp_cyc_q[$];
  int            n_pass = 0;
  int            n_total = 0;

  // Results of the most recent tick
  logic          t_got, t_acc, t_ov, t_ir;
  logic [W-1:0]  t_gd, t_ed;
  logic [TW-1:0] t_gt, t_et;
  int            t_lat;

  // Reference model straight from the op definitions.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int sh, input logic [2:0] op);
    logic [2*W-1:0] dd;
    logic [2*W-1:0] t;
    dd = {d, d};
    case (op)
      3'd0: begin t = dd << sh; model = t[2*W-1:W]; end
      3'd1: begin t = dd >> sh; model = t[W-1:0]; end
      3'd2: model = d << sh;
      3'd3: model = d >> sh;
      3'd4: model = $signed(d) >>> sh;
      default: model = d;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [4:0] sh,
                       input logic [2:0] op, input logic [TW-1:0] tag);
    in_valid = v;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
  endtask

  // One clock: observe at negedge, record accepts into the model queue, pop on consume.
  task automatic tick();
    @(negedge clk);
    t_got = 1'b0;
    t_ov  = out_valid;
    t_ir  = in_ready;
    t_gd  = out_data;
    t_gt  = out_tag;
    t_ed  = '0;
    t_et  = '0;
    t_lat = 0;
    t_acc = !rst && in_valid && in_ready;
    if (!rst && out_valid && out_ready) begin
      t_got = 1'b1;
      if (exp_q.size() == 0) begin
        t_ed = ~out_data;
        t_et = ~out_tag;
      end else begin
        t_ed  = exp_q.pop_front();
        t_et  = exp_tag_q.pop_front();
        t_lat = cyc - exp_cyc_q.pop_front();
      end
    end
    if (t_acc) begin
      exp_q.push_back(model(in_data, int'(in_shamt), in_op));
      exp_tag_q.push_back(in_tag);
      exp_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
    n_total++;
    if (out_data !== '0) $display("FAIL reset_data got %h exp 0", out_data); else n_pass++;
    n_total++;
    if (out_tag !== '0) $display("FAIL reset_tag got %0d exp 0", out_tag); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] dl[$];
    logic [4:0]   sl[$];
    logic [2:0]   ol[$];
    logic [W-1:0] el[$];
    logic [W-1:0] de;
    int           b;
    int           k;
    dl = '{32'h80000001, 32'h00000001, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    sl = '{5'd1, 5'd4, 5'd31, 5'd31, 5'd31, 5'd4};
    ol = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd2, 3'd4};
    el = '{32'h00000003, 32'h10000000, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h07FFFFFF};
    for (int op = 0; op < 8; op++) begin
      dl.push_back(32'hA5A50F0F);
      sl.push_back(5'd0);
      ol.push_back(3'(op));
      el.push_back(32'hA5A50F0F);
    end
    dl.push_back(32'hA5A50F0F);
    sl.push_back(5'd13);
    ol.push_back(3'd7);
    el.push_back(32'hA5A50F0F);

    out_ready = 1'b1;
    b = 0;
    k = 0;
    while ((b < dl.size() || exp_q.size() != 0) && k < 100) begin
      if (b < dl.size()) drive(1'b1, dl[b], sl[b], ol[b], TW'(b + 7));
      else drive(1'b0, '0, '0, '0, '0);
      tick();
      if (t_acc) b++;
      if (t_got) begin
        de = el.pop_front();
        n_total++;
        if (t_gd !== t_ed || t_gt !== t_et)
          $display("FAIL dir_result got %h/%0d exp %h/%0d", t_gd, t_gt, t_ed, t_et);
        else n_pass++;
        n_total++;
        if (t_gd !== de) $display("FAIL dir_const got %h exp %h", t_gd, de); else n_pass++;
        n_total++;
        if (t_lat != LAT) $display("FAIL dir_latency got %0d exp %0d", t_lat, LAT); else n_pass++;
      end
      k++;
    end
    n_total++;
    if (exp_q.size() != 0 || b != dl.size())
      $display("FAIL dir_drain got %0d pending exp 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random_ops();
    int b;
    int k;
    out_ready = 1'b1;
    b = 0;
    k = 0;
    while ((b < 40 || exp_q.size() != 0) && k < 400) begin
      if (b < 40 && $urandom_range(0, 3) != 0)
        drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), TW'(b));
      else drive(1'b0, $urandom, '0, '0, '0);
      tick();
      if (t_acc) b++;
      if (t_got) begin
        n_total++;
        if (t_gd !== t_ed || t_gt !== t_et)
          $display("FAIL rnd_result got %h/%0d exp %h/%0d", t_gd, t_gt, t_ed, t_et);
        else n_pass++;
        n_total++;
        if (t_lat != LAT) $display("FAIL rnd_latency got %0d exp %0d", t_lat, LAT); else n_pass++;
      end
      k++;
    end
    n_total++;
    if (exp_q.size() != 0 || b != 40) $display("FAIL rnd_drain got %0d sent exp 40", b); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int            b;
    int            k;
    int            consumed;
    logic          prev_stall;
    logic [W-1:0]  pd;
    logic [TW-1:0] pt;
    b = 0;
    k = 0;
    consumed = 0;
    prev_stall = 1'b0;
    pd = '0;
    pt = '0;
    while (consumed < 16 && k < 200) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      if (b < 16) drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), TW'(b));
      else drive(1'b0, '0, '0, '0, '0);
      tick();
      n_total++;
      if (t_ir !== !(t_ov && !out_ready))
        $display("FAIL b2b_in_ready got %b exp %b", t_ir, !(t_ov && !out_ready));
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (t_ov !== 1'b1 || t_gd !== pd || t_gt !== pt)
          $display("FAIL b2b_stable got %b/%h/%0d exp 1/%h/%0d", t_ov, t_gd, t_gt, pd, pt);
        else n_pass++;
      end
      prev_stall = t_ov && !out_ready;
      pd = t_gd;
      pt = t_gt;
      if (t_acc) b++;
      if (t_got) begin
        n_total++;
        if (t_gd !== t_ed || t_gt !== t_et || t_gt !== TW'(consumed))
          $display("FAIL b2b_result got %h/%0d exp %h/%0d", t_gd, t_gt, t_ed, TW'(consumed));
        else n_pass++;
        consumed++;
      end
      k++;
    end
    n_total++;
    if (consumed != 16 || exp_q.size() != 0)
      $display("FAIL b2b_count got %0d exp 16", consumed);
    else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_flush();
    int k;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), TW'(20 + i));
      tick();
    end
    // A beat presented during reset must be ignored.
    drive(1'b1, 32'h12345678, 5'd3, 3'd0, TW'(30));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    exp_q.delete();
    exp_tag_q.delete();
    exp_cyc_q.delete();
    out_ready = 1'b1;
    tick();
    n_total++;
    if (t_ov !== 1'b0 || t_gd !== '0 || t_gt !== '0)
      $display("FAIL flush_clear got %b/%h/%0d exp 0/0/0", t_ov, t_gd, t_gt);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (t_ov !== 1'b0) $display("FAIL flush_stale got %b exp 0", t_ov); else n_pass++;
    end
    drive(1'b1, 32'h0000F00D, 5'd8, 3'd0, TW'(9));
    tick();
    drive(1'b0, '0, '0, '0, '0);
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      tick();
      if (t_got) begin
        n_total++;
        if (t_gd !== 32'h00F00D00 || t_gt !== TW'(9) || t_gd !== t_ed)
          $display("FAIL flush_after got %h/%0d exp 00f00d00/9", t_gd, t_gt);
        else n_pass++;
        n_total++;
        if (t_lat != LAT) $display("FAIL flush_latency got %0d exp %0d", t_lat, LAT); else n_pass++;
      end
      k++;
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL flush_drain got %0d pending exp 0", exp_q.size()); else n_pass++;
  endtask

`ifdef ROT_SHIFT_ZERO_FLAG_EN
  task automatic test_zero_flag();
    logic [W-1:0] ed[2];
    logic         ez[2];
    int           n;
    ed[0] = 32'h00000000;
    ez[0] = 1'b1;
    ed[1] = 32'h80000000;
    ez[1] = 1'b0;
    n = 0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00000001, 5'd1, 3'd3, TW'(1));
    @(posedge clk);
    #1;
    drive(1'b1, 32'h00000001, 5'd31, 3'd0, TW'(2));
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid && n < 2) begin
        n_total++;
        if (out_data !== ed[n] || out_zero !== ez[n])
          $display("FAIL zero_flag got %h/%b exp %h/%b", out_data, out_zero, ed[n], ez[n]);
        else n_pass++;
        n++;
      end else begin
        n_total++;
        if (out_zero !== 1'b0) $display("FAIL zero_idle got %b exp 0", out_zero); else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    n_total++;
    if (n != 2) $display("FAIL zero_count got %0d exp 2", n); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    test_reset();
    test_directed();
    test_random_ops();
    test_back_to_back();
    test_reset_flush();
`ifdef ROT_SHIFT_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
